// File: rtl/ld_st_exec_unit_pkg.sv
// Shared types and constants for the load/store execution unit.
package ld_st_exec_unit_pkg;

    localparam int unsigned NUM_REGS  = 64;
    localparam int unsigned ROB_SIZE  = 16;
    localparam int unsigned NUM_BRATS = 4;

    localparam int unsigned PR_W   = $clog2(NUM_REGS);
    localparam int unsigned ROB_W  = $clog2(ROB_SIZE);
    localparam int unsigned BRAT_W = $clog2(NUM_BRATS);

    typedef enum logic [1:0] {IDLE, ADDR, MEM, WB} lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic              is_store;
        logic [2:0]        funct3;
        logic [31:0]       imm;
        logic [PR_W-1:0]   pr1_s_ld_st;
        logic [PR_W-1:0]   pr2_s_ld_st;
        logic [PR_W-1:0]   pd;
        logic [4:0]        rd;
        logic [ROB_W-1:0]  rob_index;
        logic [BRAT_W-1:0] current_brat;
    } ld_st_queue_t;

    // Unshifted byte-lane pattern for an access width (funct3[1:0]).
    function automatic logic [3:0] size_mask(input logic [1:0] width);
        case (width)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ld_st_exec_unit_if.sv
// Data-memory port bundle between the execution unit and dmem.
interface ld_st_exec_unit_if;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/load_data_align.sv
// Picks the addressed byte/half out of a load word and extends it to 32 bits.
module load_data_align
    import ld_st_exec_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Move the addressed lane to bit 0, then extend by load type.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/ld_st_exec_unit.sv
// Single-op memory execution unit: operand read, dmem access, CDB broadcast.
module ld_st_exec_unit
    import ld_st_exec_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               branch_recovery,
    input  logic [BRAT_W-1:0]  branch_resolved_index,
    input  logic               entry_valid,
    input  ld_st_queue_t       entry,
    output logic               entry_ready,
    output logic [PR_W-1:0]    rf_ps1,
    output logic [PR_W-1:0]    rf_ps2,
    input  logic [31:0]        rf_rs1_v,
    input  logic [31:0]        rf_rs2_v,
    ld_st_exec_unit_if.master  dmem,
    output logic               cdb_valid,
    output logic               cdb_rd_we,
    output logic [PR_W-1:0]    cdb_phys_rd,
    output logic [4:0]         cdb_arch_rd,
    output logic [ROB_W-1:0]   cdb_rob_index,
    output logic [31:0]        cdb_data,
    output logic               misaligned
);

    lsu_state_t   state, state_next;
    ld_st_queue_t entry_q;
    logic         kill_q;
    logic [1:0]   off_q;
    logic [31:0]  addr_q, wdata_q, data_q;
    logic [3:0]   rmask_q, wmask_q;

    logic [31:0]  ea;
    logic         addr_mis;
    logic [3:0]   lane_mask;
    logic         kill_idle, kill_cur, kill_mem;
    logic [31:0]  load_data;

    load_data_align u_align (
        .funct3 (entry_q.funct3),
        .offset (off_q),
        .rdata  (dmem.dmem_rdata),
        .data   (load_data)
    );

    // Address generation, alignment and kill decode for the current op.
    always_comb begin
        ea        = rf_rs1_v + entry_q.imm;
        addr_mis  = ((entry_q.funct3[1:0] == 2'b01) && ea[0]) ||
                    ((entry_q.funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        lane_mask = size_mask(entry_q.funct3[1:0]) << ea[1:0];
        // In IDLE nothing is captured yet, so test the incoming entry's tag.
        kill_idle = flush ||
                    (branch_recovery && (entry.current_brat > branch_resolved_index));
        kill_cur  = flush ||
                    (branch_recovery && (entry_q.current_brat > branch_resolved_index));
        // Stores only issue at the ROB head; recovery cannot squash them.
        kill_mem  = flush || (branch_recovery && !entry_q.is_store &&
                    (entry_q.current_brat > branch_resolved_index));
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (entry_valid && !kill_idle) state_next = ADDR;
            ADDR: begin
                if (kill_cur)      state_next = IDLE;
                else if (addr_mis) state_next = WB;
                else               state_next = MEM;
            end
            MEM: begin
                // The request is never abandoned; a kill only suppresses WB.
                if (dmem.dmem_resp) state_next = (kill_q || kill_mem) ? IDLE : WB;
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, captured entry and registered dmem request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            entry_q <= '0;
            kill_q  <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (entry_valid && !kill_idle) entry_q <= entry;
                end
                ADDR: begin
                    if (!kill_cur) begin
                        off_q  <= ea[1:0];
                        data_q <= '0;
                        if (!addr_mis) begin
                            addr_q  <= {ea[31:2], 2'b00};
                            wdata_q <= rf_rs2_v << {ea[1:0], 3'b000};
                            rmask_q <= entry_q.is_store ? 4'b0000 : lane_mask;
                            wmask_q <= entry_q.is_store ? lane_mask : 4'b0000;
                        end
                    end
                end
                MEM: begin
                    if (dmem.dmem_resp) begin
                        rmask_q <= '0;
                        wmask_q <= '0;
                        kill_q  <= 1'b0;
                        data_q  <= entry_q.is_store ? 32'h0 : load_data;
                    end else if (kill_mem) begin
                        kill_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_rmask = rmask_q;
    assign dmem.dmem_wmask = wmask_q;
    assign dmem.dmem_wdata = wdata_q;

    // Handshake, register-file and CDB outputs; all zero outside their state.
    always_comb begin
        entry_ready   = (state == IDLE);
        rf_ps1        = '0;
        rf_ps2        = '0;
        misaligned    = 1'b0;
        cdb_valid     = 1'b0;
        cdb_rd_we     = 1'b0;
        cdb_phys_rd   = '0;
        cdb_arch_rd   = '0;
        cdb_rob_index = '0;
        cdb_data      = '0;
        if (state == ADDR) begin
            rf_ps1     = entry_q.pr1_s_ld_st;
            rf_ps2     = entry_q.pr2_s_ld_st;
            misaligned = addr_mis && !kill_cur;
        end
        if ((state == WB) && !kill_q && !kill_cur) begin
            cdb_valid     = 1'b1;
            cdb_rd_we     = !entry_q.is_store;
            cdb_phys_rd   = entry_q.pd;
            cdb_arch_rd   = entry_q.rd;
            cdb_rob_index = entry_q.rob_index;
            cdb_data      = data_q;
        end
    end

endmodule

// File: tb/tb_ld_st_exec_unit.sv
// Self-checking bench: directed vector table, random ops vs. a reference model,
// and hand sequences for kill and reset corner cases.
module tb_ld_st_exec_unit;
    import ld_st_exec_unit_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               branch_recovery;
    logic [BRAT_W-1:0]  branch_resolved_index;
    logic               entry_valid;
    ld_st_queue_t       entry;
    logic               entry_ready;
    logic [PR_W-1:0]    rf_ps1, rf_ps2;
    logic [31:0]        rf_rs1_v, rf_rs2_v;
    logic               cdb_valid, cdb_rd_we, misaligned;
    logic [PR_W-1:0]    cdb_phys_rd;
    logic [4:0]         cdb_arch_rd;
    logic [ROB_W-1:0]   cdb_rob_index;
    logic [31:0]        cdb_data;
    logic [31:0]        regs [NUM_REGS];

    int total = 0;
    int bad   = 0;

    ld_st_exec_unit_if dmem_bus ();

    ld_st_exec_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .branch_recovery       (branch_recovery),
        .branch_resolved_index (branch_resolved_index),
        .entry_valid           (entry_valid),
        .entry                 (entry),
        .entry_ready           (entry_ready),
        .rf_ps1                (rf_ps1),
        .rf_ps2                (rf_ps2),
        .rf_rs1_v              (rf_rs1_v),
        .rf_rs2_v              (rf_rs2_v),
        .dmem                  (dmem_bus),
        .cdb_valid             (cdb_valid),
        .cdb_rd_we             (cdb_rd_we),
        .cdb_phys_rd           (cdb_phys_rd),
        .cdb_arch_rd           (cdb_arch_rd),
        .cdb_rob_index         (cdb_rob_index),
        .cdb_data              (cdb_data),
        .misaligned            (misaligned)
    );

    assign rf_rs1_v = regs[rf_ps1];
    assign rf_rs2_v = regs[rf_ps2];

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] rs1, imm, rs2, rdata;
        int          waits;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_rmask, exp_wmask;
        logic [31:0] exp_wdata, exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-address arithmetic straight from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] ea;
        int nb, off, mask;
        longint unsigned lim, val;
        ea  = v.rs1 + v.imm;
        off = int'(ea % 4);
        nb  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        r.exp_mis   = (ea % nb) != 0;
        r.exp_addr  = ea - 32'(off);
        mask        = ((1 << nb) - 1) << off;
        r.exp_rmask = v.st ? 4'h0 : mask[3:0];
        r.exp_wmask = v.st ? mask[3:0] : 4'h0;
        r.exp_wdata = v.rs2 << (8 * off);
        if (v.st || r.exp_mis) begin
            r.exp_data = 32'h0;
        end else begin
            lim = 64'd1 << (8 * nb);
            val = (64'(v.rdata) >> (8 * off)) % lim;
            if (!v.f3[2] && nb < 4 && val >= lim / 2) val = val + (64'h1_0000_0000 - lim);
            r.exp_data = val[31:0];
        end
        return r;
    endfunction

    // Present one entry for a cycle; returns at the negedge inside ADDR.
    task automatic issue(input ld_st_queue_t e);
        chk("ready_before_issue", 32'(entry_ready), 32'd1);
        entry       = e;
        entry_valid = 1'b1;
        @(negedge clk);
        entry_valid = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        ld_st_queue_t e;
        logic [PR_W-1:0] p1, p2;
        p1 = PR_W'($urandom_range(1, 31));
        p2 = p1 + PR_W'(32);
        regs[p1] = v.rs1;
        regs[p2] = v.rs2;
        e = '0;
        e.is_store     = v.st;
        e.funct3       = v.f3;
        e.imm          = v.imm;
        e.pr1_s_ld_st  = p1;
        e.pr2_s_ld_st  = p2;
        e.pd           = PR_W'($urandom);
        e.rd           = 5'($urandom);
        e.rob_index    = ROB_W'($urandom);
        e.current_brat = BRAT_W'($urandom);
        issue(e);
        chk("addr_ps1", 32'(rf_ps1), 32'(p1));
        chk("addr_ps2", 32'(rf_ps2), 32'(p2));
        chk("addr_misaligned", 32'(misaligned), 32'(v.exp_mis));
        chk("addr_ready", 32'(entry_ready), 32'd0);
        if (!v.exp_mis) begin
            @(negedge clk);
            chk("mem_addr", dmem_bus.dmem_addr, v.exp_addr);
            chk("mem_rmask", 32'(dmem_bus.dmem_rmask), 32'(v.exp_rmask));
            chk("mem_wmask", 32'(dmem_bus.dmem_wmask), 32'(v.exp_wmask));
            if (v.st) chk("mem_wdata", dmem_bus.dmem_wdata, v.exp_wdata);
            chk("mem_cdb_idle", 32'(cdb_valid), 32'd0);
            for (int i = 0; i <= v.waits; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    chk("mem_rmask_held", 32'(dmem_bus.dmem_rmask), 32'(v.exp_rmask));
                    chk("mem_wmask_held", 32'(dmem_bus.dmem_wmask), 32'(v.exp_wmask));
                    chk("mem_no_cdb", 32'(cdb_valid), 32'd0);
                end
                dmem_bus.dmem_resp  = (i == v.waits);
                dmem_bus.dmem_rdata = v.rdata;
            end
        end
        @(negedge clk);
        dmem_bus.dmem_resp = 1'b0;
        chk("wb_valid", 32'(cdb_valid), 32'd1);
        chk("wb_rd_we", 32'(cdb_rd_we), 32'(!v.st));
        chk("wb_data", cdb_data, v.exp_data);
        chk("wb_phys_rd", 32'(cdb_phys_rd), 32'(e.pd));
        chk("wb_arch_rd", 32'(cdb_arch_rd), 32'(e.rd));
        chk("wb_rob", 32'(cdb_rob_index), 32'(e.rob_index));
        chk("wb_masks_clear", 32'({dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}), 32'd0);
        chk("wb_ready", 32'(entry_ready), 32'd0);
        @(negedge clk);
        chk("idle_cdb_low", 32'(cdb_valid), 32'd0);
    endtask

    function automatic ld_st_queue_t mk_entry(input logic st, input logic [2:0] f3,
                                              input logic [BRAT_W-1:0] brat);
        ld_st_queue_t e = '0;
        e.is_store     = st;
        e.funct3       = f3;
        e.pr1_s_ld_st  = PR_W'(5);
        e.pr2_s_ld_st  = PR_W'(6);
        e.current_brat = brat;
        return e;
    endfunction

    vec_t vecs [10];
    vec_t rv;

    initial begin
        rst = 1'b1; flush = 1'b0; branch_recovery = 1'b0; branch_resolved_index = '0;
        entry_valid = 1'b0; entry = '0;
        dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(entry_ready), 32'd1);
        chk("rst_addr", dmem_bus.dmem_addr, 32'h0);
        chk("rst_masks", 32'({dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}), 32'd0);
        chk("rst_wdata", dmem_bus.dmem_wdata, 32'h0);
        chk("rst_cdb", 32'({cdb_valid, cdb_rd_we, misaligned}), 32'd0);
        chk("rst_cdb_data", cdb_data, 32'h0);
        chk("rst_ps1", 32'(rf_ps1), 32'd0);

        // st f3 rs1 imm rs2 rdata waits | mis addr rmask wmask wdata data
        vecs[0] = '{0, F3_LW,  32'h1000, 32'd4, 32'h0, 32'hDEADBEEF, 2,
                    0, 32'h1004, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{0, F3_LB,  32'h1000, 32'd3, 32'h0, 32'h80FFFFFF, 1,
                    0, 32'h1000, 4'h8, 4'h0, 32'h0, 32'hFFFFFF80};
        vecs[2] = '{0, F3_LBU, 32'h1000, 32'd3, 32'h0, 32'h80FFFFFF, 1,
                    0, 32'h1000, 4'h8, 4'h0, 32'h0, 32'h00000080};
        vecs[3] = '{1, F3_SH,  32'h2000, 32'd2, 32'h0000ABCD, 32'h5555AAAA, 1,
                    0, 32'h2000, 4'h0, 4'hC, 32'hABCD0000, 32'h0};
        vecs[4] = '{0, F3_LW,  32'h1000, 32'd2, 32'h0, 32'h12345678, 1,
                    1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vecs[5] = '{0, F3_LHU, 32'hFFFFFFFE, 32'd4, 32'h0, 32'h12345678, 3,
                    0, 32'h0, 4'hC, 4'h0, 32'h0, 32'h00001234};
        vecs[6] = '{0, F3_LH,  32'h100, 32'hFFFFFFFE, 32'h0, 32'h80010000, 1,
                    0, 32'hFC, 4'hC, 4'h0, 32'h0, 32'hFFFF8001};
        vecs[7] = '{1, F3_SB,  32'h3000, 32'd1, 32'h12345678, 32'h0, 2,
                    0, 32'h3000, 4'h0, 4'h2, 32'h34567800, 32'h0};
        vecs[8] = '{1, F3_SW,  32'h10, 32'd1, 32'hCAFEF00D, 32'h0, 1,
                    1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vecs[9] = '{0, F3_LH,  32'h5, 32'd0, 32'h0, 32'h0, 1,
                    1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // Random operations checked against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] ldf [5];
            ldf[0] = F3_LB; ldf[1] = F3_LH; ldf[2] = F3_LW; ldf[3] = F3_LBU; ldf[4] = F3_LHU;
            rv = vecs[0];
            rv.st    = 1'($urandom);
            rv.f3    = rv.st ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
            rv.rs1   = $urandom;
            if ($urandom_range(0, 3) != 0) rv.rs1[1:0] = 2'b00;
            rv.imm   = 32'($urandom_range(0, 63)) - 32'd32;
            rv.rs2   = $urandom;
            rv.rdata = $urandom;
            rv.waits = $urandom_range(1, 3);
            do_op(model(rv));
        end

        // Flush while the request is outstanding: held until resp, no WB.
        regs[5] = 32'h1000;
        issue(mk_entry(0, F3_LW, 2'd0));
        @(negedge clk);
        chk("flush_mem_rmask", 32'(dmem_bus.dmem_rmask), 32'hF);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("flush_mem_held", 32'(dmem_bus.dmem_rmask), 32'hF);
            chk("flush_mem_addr", dmem_bus.dmem_addr, 32'h1000);
            @(negedge clk);
        end
        chk("flush_mem_held_last", 32'(dmem_bus.dmem_rmask), 32'hF);
        dmem_bus.dmem_resp = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_resp = 1'b0;
        chk("flush_mem_no_cdb", 32'(cdb_valid), 32'd0);
        chk("flush_mem_idle", 32'(entry_ready), 32'd1);
        chk("flush_mem_rmask_clr", 32'(dmem_bus.dmem_rmask), 32'd0);
        @(negedge clk);
        chk("flush_mem_no_cdb2", 32'(cdb_valid), 32'd0);

        // Recovery in ADDR with younger tag (3 > 1): squashed straight to IDLE.
        issue(mk_entry(0, F3_LW, 2'd3));
        branch_recovery = 1'b1; branch_resolved_index = 2'd1;
        @(negedge clk);
        branch_recovery = 1'b0;
        chk("brk_addr_idle", 32'(entry_ready), 32'd1);
        chk("brk_addr_masks", 32'({dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}), 32'd0);
        chk("brk_addr_no_cdb", 32'(cdb_valid), 32'd0);

        // Equal tag (1 == 1) survives recovery.
        issue(mk_entry(0, F3_LW, 2'd1));
        branch_recovery = 1'b1;
        @(negedge clk);
        branch_recovery = 1'b0;
        chk("brk_eq_mem", 32'(dmem_bus.dmem_rmask), 32'hF);
        dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        dmem_bus.dmem_resp = 1'b0;
        chk("brk_eq_cdb", 32'(cdb_valid), 32'd1);
        chk("brk_eq_data", cdb_data, 32'h0BADF00D);
        @(negedge clk);

        // Store in MEM is not squashed by recovery.
        regs[6] = 32'h11223344;
        issue(mk_entry(1, F3_SW, 2'd3));
        @(negedge clk);
        branch_recovery = 1'b1;
        @(negedge clk);
        branch_recovery = 1'b0;
        chk("st_brk_held", 32'(dmem_bus.dmem_wmask), 32'hF);
        dmem_bus.dmem_resp = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_resp = 1'b0;
        chk("st_brk_cdb", 32'(cdb_valid), 32'd1);
        chk("st_brk_rd_we", 32'(cdb_rd_we), 32'd0);
        @(negedge clk);

        // Flush during WB forces cdb_valid low in that cycle.
        regs[5] = 32'h1001;
        issue(mk_entry(0, F3_LW, 2'd0));
        chk("wb_kill_mis", 32'(misaligned), 32'd1);
        @(negedge clk);
        chk("wb_kill_pre", 32'(cdb_valid), 32'd1);
        flush = 1'b1;
        #1;
        chk("wb_kill_cdb", 32'(cdb_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("wb_kill_idle", 32'(entry_ready), 32'd1);

        // Flush in IDLE: entry is not captured.
        entry = mk_entry(0, F3_LW, 2'd0);
        entry_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        entry_valid = 1'b0; flush = 1'b0;
        chk("idle_kill_ready", 32'(entry_ready), 32'd1);
        chk("idle_kill_ps1", 32'(rf_ps1), 32'd0);

        // Reset while in MEM; a later response is ignored.
        regs[5] = 32'h4000;
        issue(mk_entry(0, F3_LW, 2'd0));
        @(negedge clk);
        chk("rst_mem_pre", 32'(dmem_bus.dmem_rmask), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_ready", 32'(entry_ready), 32'd1);
        chk("rst_mem_masks", 32'({dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}), 32'd0);
        chk("rst_mem_addr", dmem_bus.dmem_addr, 32'h0);
        chk("rst_mem_cdb", 32'({cdb_valid, misaligned}), 32'd0);
        dmem_bus.dmem_resp = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_resp = 1'b0;
        chk("rst_late_resp_cdb", 32'(cdb_valid), 32'd0);
        chk("rst_late_resp_ready", 32'(entry_ready), 32'd1);
        @(negedge clk);
        chk("rst_late_resp_cdb2", 32'(cdb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
